x87_host_ctrl: RTL and testbench

CPU-side initiator for the x87 execution core. It accepts one FPU instruction from the pipeline and fetches any 32/64-bit memory operand over a 32-bit memory port. It then drives the core's start/opcode/operand inputs and waits for done. A memory store produced by the core is split into 32-bit writes. Completion, write-back and fault status are returned to the pipeline.

---
 rtl/x87_pkg.sv | 40 ++++
 rtl/x87_store_split.sv | 30 +++
 rtl/x87_host_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_x87_host_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/x87_pkg.sv
// Shared types and encodings for the x87 host-side controller.
package x87_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_LO,
        S_LD_HI,
        S_ISSUE,
        S_WAIT,
        S_ST_LO,
        S_ST_HI,
        S_RESP
    } state_t;

    localparam logic [1:0] LD_NONE = 2'd0;
    localparam logic [1:0] LD_32   = 2'd1;
    localparam logic [1:0] LD_64   = 2'd2;
    localparam logic [1:0] LD_RSV  = 2'd3;

    localparam logic [1:0] ST_16  = 2'd0;
    localparam logic [1:0] ST_32  = 2'd1;
    localparam logic [1:0] ST_64  = 2'd2;
    localparam logic [1:0] ST_RSV = 2'd3;

    localparam logic [2:0] WB_NONE    = 3'd0;
    localparam logic [2:0] WB_STATUS  = 3'd1;
    localparam logic [2:0] WB_CONTROL = 3'd2;
    localparam logic [2:0] WB_TAG     = 3'd3;

    // 16-bit stores only need halfword alignment; wider stores need word alignment.
    function automatic logic store_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size == ST_RSV)
            return 1'b1;
        else if (size == ST_16)
            return addr_lo[0];
        else
            return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/x87_store_split.sv
// Maps a right-aligned core store onto byte enables and data for the two 32-bit write beats.
module x87_store_split
    import x87_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        addr1,
    input  logic [63:0] data64,
    output logic [3:0]  lo_be,
    output logic [31:0] lo_wdata,
    output logic [3:0]  hi_be,
    output logic [31:0] hi_wdata
);

    always_comb begin
        lo_be    = 4'hF;
        lo_wdata = data64[31:0];
        hi_be    = 4'hF;
        hi_wdata = data64[63:32];
        if (size == ST_16) begin
            if (addr1) begin
                lo_be    = 4'b1100;
                lo_wdata = {data64[15:0], 16'h0000};
            end else begin
                lo_be    = 4'b0011;
                lo_wdata = {16'h0000, data64[15:0]};
            end
        end
    end

endmodule

// File: rtl/x87_host_ctrl.sv
// CPU-side initiator for the x87 core: operand fetch, issue, wait, store split and response.
module x87_host_ctrl
    import x87_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op1,
    input  logic [7:0]  req_op2,
    input  logic        req_op2_valid,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_load,
    output logic        done_valid,
    output logic        done_fault,
    output logic        done_wb_valid,
    output logic [2:0]  done_wb_kind,
    output logic [15:0] done_wb_value,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        fpu_start,
    output logic [7:0]  fpu_op1,
    output logic [7:0]  fpu_op2,
    output logic        fpu_op2_valid,
    output logic [31:0] fpu_mem32,
    output logic [63:0] fpu_mem64,
    input  logic        fpu_busy,
    input  logic        fpu_done,
    input  logic        fpu_wb_valid,
    input  logic [2:0]  fpu_wb_kind,
    input  logic [15:0] fpu_wb_value,
    input  logic        memstore_valid,
    input  logic [1:0]  memstore_size,
    input  logic [63:0] memstore_data64
);

    state_t            state_q, state_d;
    logic [7:0]        op1_q, op2_q;
    logic              op2v_q;
    logic [31:0]       addr_q;
    logic [1:0]        load_q;
    logic [31:0]       mem32_q;
    logic [63:0]       mem64_q;
    logic              st_vld_q;
    logic [1:0]        st_size_q;
    logic [63:0]       st_data_q;
    logic              wb_vld_q;
    logic [2:0]        wb_kind_q;
    logic [15:0]       wb_value_q;
    logic              fault_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic              req_bad, st_any, st_bad, to_hit;
    logic [1:0]        st_size_eff;
    logic [31:0]       addr_hi;
    logic [3:0]        lo_be, hi_be;
    logic [31:0]       lo_wdata, hi_wdata;
    logic              unused_busy;

    assign unused_busy = fpu_busy;

    assign req_bad     = (req_load == LD_RSV) || ((req_load != LD_NONE) && (req_addr[1:0] != 2'b00));
    // A store arriving together with fpu_done must steer the same decision.
    assign st_any      = memstore_valid | st_vld_q;
    assign st_size_eff = memstore_valid ? memstore_size : st_size_q;
    assign st_bad      = store_bad(st_size_eff, addr_q[1:0]);
    assign to_hit      = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign addr_hi     = addr_q + 32'd4;

    x87_store_split u_split (
        .size     (st_size_q),
        .addr1    (addr_q[1]),
        .data64   (st_data_q),
        .lo_be    (lo_be),
        .lo_wdata (lo_wdata),
        .hi_be    (hi_be),
        .hi_wdata (hi_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'h0;
        mem_be        = 4'h0;
        mem_wdata     = 32'h0;
        fpu_start     = 1'b0;
        done_valid    = 1'b0;
        done_fault    = 1'b0;
        done_wb_valid = 1'b0;
        done_wb_kind  = 3'd0;
        done_wb_value = 16'h0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)
                        state_d = S_RESP;
                    else if (req_load != LD_NONE)
                        state_d = S_LD_LO;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_LD_LO: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                mem_be   = 4'hF;
                if (mem_ack)
                    state_d = (load_q == LD_64) ? S_LD_HI : S_ISSUE;
            end
            S_LD_HI: begin
                mem_req  = 1'b1;
                mem_addr = addr_hi;
                mem_be   = 4'hF;
                if (mem_ack)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                fpu_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_done)
                    state_d = (st_any && !st_bad) ? S_ST_LO : S_RESP;
                else if (to_hit)
                    state_d = S_RESP;
            end
            S_ST_LO: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = lo_be;
                mem_wdata = lo_wdata;
                if (mem_ack)
                    state_d = (st_size_q == ST_64) ? S_ST_HI : S_RESP;
            end
            S_ST_HI: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_hi;
                mem_be    = hi_be;
                mem_wdata = hi_wdata;
                if (mem_ack)
                    state_d = S_RESP;
            end
            S_RESP: begin
                done_valid = 1'b1;
                done_fault = fault_q;
                if (!fault_q) begin
                    done_wb_valid = wb_vld_q;
                    done_wb_kind  = wb_kind_q;
                    done_wb_value = wb_value_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q      <= 8'h0;
            op2_q      <= 8'h0;
            op2v_q     <= 1'b0;
            addr_q     <= 32'h0;
            load_q     <= LD_NONE;
            mem32_q    <= 32'h0;
            mem64_q    <= 64'h0;
            st_vld_q   <= 1'b0;
            st_size_q  <= ST_16;
            st_data_q  <= 64'h0;
            wb_vld_q   <= 1'b0;
            wb_kind_q  <= WB_NONE;
            wb_value_q <= 16'h0;
            fault_q    <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op1_q   <= req_op1;
                        op2_q   <= req_op2;
                        op2v_q  <= req_op2_valid;
                        addr_q  <= req_addr;
                        load_q  <= req_load;
                        mem32_q <= 32'h0;
                        mem64_q <= 64'h0;
                        fault_q <= req_bad;
                    end
                end
                S_LD_LO: begin
                    if (mem_ack) begin
                        mem32_q        <= mem_rdata;
                        mem64_q[31:0]  <= mem_rdata;
                    end
                end
                S_LD_HI: begin
                    if (mem_ack)
                        mem64_q[63:32] <= mem_rdata;
                end
                S_ISSUE: begin
                    to_cnt_q   <= '0;
                    st_vld_q   <= 1'b0;
                    wb_vld_q   <= 1'b0;
                    wb_kind_q  <= WB_NONE;
                    wb_value_q <= 16'h0;
                end
                S_WAIT: begin
                    if (memstore_valid) begin
                        st_vld_q  <= 1'b1;
                        st_size_q <= memstore_size;
                        st_data_q <= memstore_data64;
                    end
                    if (fpu_wb_valid) begin
                        wb_vld_q   <= 1'b1;
                        wb_kind_q  <= fpu_wb_kind;
                        wb_value_q <= fpu_wb_value;
                    end
                    if (fpu_done) begin
                        if (st_any && st_bad)
                            fault_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (to_hit)
                            fault_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_op1       = op1_q;
    assign fpu_op2       = op2_q;
    assign fpu_op2_valid = op2v_q;
    assign fpu_mem32     = mem32_q;
    assign fpu_mem64     = mem64_q;

endmodule

// File: tb/tb_x87_host_ctrl.sv
// Directed bench for x87_host_ctrl: loads, stores, faults, timeout and asynchronous reset.
module tb_x87_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [7:0]  req_op1, req_op2;
    logic        req_op2_valid;
    logic [31:0] req_addr;
    logic [1:0]  req_load;
    logic        done_valid, done_fault, done_wb_valid;
    logic [2:0]  done_wb_kind;
    logic [15:0] done_wb_value;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        fpu_start;
    logic [7:0]  fpu_op1, fpu_op2;
    logic        fpu_op2_valid;
    logic [31:0] fpu_mem32;
    logic [63:0] fpu_mem64;
    logic        fpu_busy, fpu_done, fpu_wb_valid;
    logic [2:0]  fpu_wb_kind;
    logic [15:0] fpu_wb_value;
    logic        memstore_valid;
    logic [1:0]  memstore_size;
    logic [63:0] memstore_data64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    x87_host_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op1(req_op1), .req_op2(req_op2),
        .req_op2_valid(req_op2_valid), .req_addr(req_addr), .req_load(req_load),
        .done_valid(done_valid), .done_fault(done_fault), .done_wb_valid(done_wb_valid),
        .done_wb_kind(done_wb_kind), .done_wb_value(done_wb_value),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fpu_start(fpu_start), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_op2_valid(fpu_op2_valid),
        .fpu_mem32(fpu_mem32), .fpu_mem64(fpu_mem64), .fpu_busy(fpu_busy), .fpu_done(fpu_done),
        .fpu_wb_valid(fpu_wb_valid), .fpu_wb_kind(fpu_wb_kind), .fpu_wb_value(fpu_wb_value),
        .memstore_valid(memstore_valid), .memstore_size(memstore_size),
        .memstore_data64(memstore_data64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic request(input logic [7:0] op1, input logic [31:0] addr, input logic [1:0] load);
        req_valid     = 1'b1;
        req_op1       = op1;
        req_op2       = 8'hE8;
        req_op2_valid = 1'b1;
        req_addr      = addr;
        req_load      = load;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 0; req_op1 = 0; req_op2 = 0; req_op2_valid = 0; req_addr = 0; req_load = 0;
        mem_ack = 0; mem_rdata = 0; fpu_busy = 0; fpu_done = 0;
        fpu_wb_valid = 0; fpu_wb_kind = 0; fpu_wb_value = 0;
        memstore_valid = 0; memstore_size = 0; memstore_data64 = 0;

        step();
        check("rst_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_done", done_valid, 0);
        check("rst_start", fpu_start, 0);
        check("rst_op1", fpu_op1, 0);
        check("rst_mem64", fpu_mem64, 0);

        // No-memory op.
        rst_n = 1'b1;
        request(8'hD9, 32'h0, 2'd0);
        step();
        req_valid = 0;
        check("nm_start", fpu_start, 1);
        check("nm_ready", req_ready, 0);
        check("nm_mem_req", mem_req, 0);
        check("nm_op1", fpu_op1, 8'hD9);
        check("nm_op2", fpu_op2, 8'hE8);
        check("nm_op2v", fpu_op2_valid, 1);
        step();
        check("nm_start_pulse", fpu_start, 0);
        repeat (4) step();
        fpu_done = 1;
        step();
        fpu_done = 0;
        check("nm_done", done_valid, 1);
        check("nm_fault", done_fault, 0);
        check("nm_wbv", done_wb_valid, 0);
        step();
        check("nm_done_clr", done_valid, 0);
        check("nm_ready_back", req_ready, 1);

        // 64-bit load at 0x1000.
        request(8'hDD, 32'h1000, 2'd2);
        step();
        req_valid = 0;
        check("ld_req", mem_req, 1);
        check("ld_we", mem_we, 0);
        check("ld_addr_lo", mem_addr, 32'h1000);
        check("ld_be", mem_be, 4'hF);
        step();
        check("ld_hold_addr", mem_addr, 32'h1000);
        mem_ack = 1; mem_rdata = 32'h0000_0000;
        step();
        check("ld_hi_req", mem_req, 1);
        check("ld_addr_hi", mem_addr, 32'h1004);
        mem_rdata = 32'h3FF0_0000;
        step();
        mem_ack = 0;
        check("ld_start", fpu_start, 1);
        check("ld_no_req", mem_req, 0);
        check("ld_mem64", fpu_mem64, 64'h3FF0_0000_0000_0000);
        check("ld_mem32", fpu_mem32, 32'h0);
        step(); step();
        check("ld_mem64_wait", fpu_mem64, 64'h3FF0_0000_0000_0000);
        fpu_done = 1;
        step();
        fpu_done = 0;
        check("ld_done", done_valid, 1);
        check("ld_mem64_resp", fpu_mem64, 64'h3FF0_0000_0000_0000);
        step();

        // 64-bit store at 0x2000, store coincident with done.
        request(8'hDD, 32'h2000, 2'd0);
        step();
        req_valid = 0;
        step();
        memstore_valid = 1; memstore_size = 2'd2; memstore_data64 = 64'h4009_21FB_5444_2D18;
        fpu_done = 1;
        step();
        memstore_valid = 0; fpu_done = 0;
        check("st64_req", mem_req, 1);
        check("st64_we", mem_we, 1);
        check("st64_addr_lo", mem_addr, 32'h2000);
        check("st64_be_lo", mem_be, 4'hF);
        check("st64_wd_lo", mem_wdata, 32'h5444_2D18);
        check("st64_no_done", done_valid, 0);
        step();
        check("st64_hold", mem_wdata, 32'h5444_2D18);
        mem_ack = 1;
        step();
        check("st64_addr_hi", mem_addr, 32'h2004);
        check("st64_be_hi", mem_be, 4'hF);
        check("st64_wd_hi", mem_wdata, 32'h4009_21FB);
        step();
        mem_ack = 0;
        check("st64_done", done_valid, 1);
        check("st64_fault", done_fault, 0);
        check("st64_no_req", mem_req, 0);
        step();

        // 16-bit store at 0x3002 with write-back, captured before done.
        request(8'hDF, 32'h3002, 2'd0);
        step();
        req_valid = 0;
        step();
        memstore_valid = 1; memstore_size = 2'd0; memstore_data64 = 64'hABCD;
        fpu_wb_valid = 1; fpu_wb_kind = 3'd1; fpu_wb_value = 16'h3800;
        step();
        memstore_valid = 0; fpu_wb_valid = 0;
        fpu_done = 1;
        step();
        fpu_done = 0;
        check("st16_addr", mem_addr, 32'h3000);
        check("st16_be", mem_be, 4'b1100);
        check("st16_wd", mem_wdata, 32'hABCD_0000);
        check("st16_we", mem_we, 1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        check("st16_done", done_valid, 1);
        check("st16_fault", done_fault, 0);
        check("st16_wbv", done_wb_valid, 1);
        check("st16_wbk", done_wb_kind, 3'd1);
        check("st16_wbval", done_wb_value, 16'h3800);
        step();

        // Misaligned load.
        request(8'hDD, 32'h1001, 2'd2);
        step();
        req_valid = 0;
        check("mis_ld_done", done_valid, 1);
        check("mis_ld_fault", done_fault, 1);
        check("mis_ld_no_req", mem_req, 0);
        step();
        check("mis_ld_fault_clr", done_fault, 0);

        // Misaligned 32-bit store.
        request(8'hD9, 32'h5002, 2'd0);
        step();
        req_valid = 0;
        step();
        memstore_valid = 1; memstore_size = 2'd1; memstore_data64 = 64'h1234_5678;
        fpu_done = 1;
        step();
        memstore_valid = 0; fpu_done = 0;
        check("mis_st_done", done_valid, 1);
        check("mis_st_fault", done_fault, 1);
        check("mis_st_no_req", mem_req, 0);
        step();

        // Timeout with a discarded write-back.
        request(8'hD9, 32'h0, 2'd0);
        step();
        req_valid = 0;
        check("to_start", fpu_start, 1);
        n = 0;
        while (n < 40) begin
            step();
            n++;
            fpu_wb_valid = (n == 1);
            fpu_wb_kind = 3'd2; fpu_wb_value = 16'h1234;
            if (done_valid) break;
        end
        fpu_wb_valid = 0;
        check("to_latency", n, 17);
        check("to_fault", done_fault, 1);
        check("to_wbv", done_wb_valid, 0);
        check("to_wbval", done_wb_value, 0);
        step();

        // Asynchronous reset during LD_HI.
        request(8'hDD, 32'h4000, 2'd2);
        step();
        req_valid = 0;
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 0;
        check("rst_ldhi_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_req", mem_req, 0);
        check("rst_async_ready", req_ready, 1);
        check("rst_async_mem64", fpu_mem64, 0);
        step();
        rst_n = 1'b1;
        request(8'hD8, 32'h0, 2'd0);
        step();
        req_valid = 0;
        check("post_rst_start", fpu_start, 1);
        check("post_rst_op1", fpu_op1, 8'hD8);
        step();
        fpu_done = 1;
        step();
        fpu_done = 0;
        check("post_rst_done", done_valid, 1);
        check("post_rst_fault", done_fault, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
